// File: rtl/beep_tone_sequencer_if.sv
// Control/playback bundle between the note writer and the beeper sequencer.
// The slave side is the sequencer; the master side is the controller that feeds it.
interface beep_tone_sequencer_if;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  song_len;
    logic        loop;
    logic        start;
    logic        stop;
    logic        pwm_en;
    logic [31:0] pwm_arr;
    logic [31:0] pwm_ccr;
    logic        busy;
    logic [4:0]  note_idx;
    logic        done;

    modport master (
        output wr_en, wr_addr, wr_data, song_len, loop, start, stop,
        input  pwm_en, pwm_arr, pwm_ccr, busy, note_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, song_len, loop, start, stop,
        output pwm_en, pwm_arr, pwm_ccr, busy, note_idx, done
    );
endinterface

// File: rtl/beep_tone_sequencer.sv
// Melody player: walks a 32-entry note RAM and drives the PWM generator's en/arr/ccr.
// Each note is LOAD (1 cycle), then tone, then a silent gap; GAP_CYCLES is assumed >= 1.
module beep_tone_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int DUTY_SHIFT  = 1
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n,
    beep_tone_sequencer_if.slave bus
);
    localparam int CW = $clog2(16 * BEAT_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] TONE = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_note_idx;
    logic [5:0]    r_song_len;
    logic          r_pwm_en;
    logic [31:0]   r_pwm_arr;
    logic [31:0]   r_pwm_ccr;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_ram [0:31];

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [4:0]    w_idx_nxt;
    logic [5:0]    w_len_nxt;
    logic          w_en_nxt;
    logic [31:0]   w_arr_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_song_end;
    logic [7:0]    w_entry;
    logic [3:0]    w_code;
    logic [4:0]    w_beats;
    logic [CW-1:0] w_tone_cnt;
    logic [5:0]    w_idx_inc;

    function automatic logic [31:0] f_oct4_arr(input logic [2:0] n);
        case (n)
            3'd1:    f_oct4_arr = 32'd191109;
            3'd2:    f_oct4_arr = 32'd170264;
            3'd3:    f_oct4_arr = 32'd151684;
            3'd4:    f_oct4_arr = 32'd143171;
            3'd5:    f_oct4_arr = 32'd127550;
            3'd6:    f_oct4_arr = 32'd113635;
            3'd7:    f_oct4_arr = 32'd101238;
            default: f_oct4_arr = 32'd0;
        endcase
    endfunction

    // Codes 8..14 are the octave-4 period halved (one octave up).
    function automatic logic [31:0] f_tone_arr(input logic [3:0] code);
        logic [3:0] n;
        if (code > 4'd7) begin
            n          = code - 4'd7;
            f_tone_arr = f_oct4_arr(n[2:0]) >> 1;
        end else begin
            n          = code;
            f_tone_arr = f_oct4_arr(n[2:0]);
        end
    endfunction

    assign w_entry    = r_ram[r_note_idx];
    assign w_code     = w_entry[7:4];
    assign w_beats    = (w_entry[3:0] == 4'd0) ? 5'd16 : {1'b0, w_entry[3:0]};
    assign w_tone_cnt = CW'(w_beats) * CW'(BEAT_CYCLES) - CW'(GAP_CYCLES) - CW'(1);
    assign w_idx_inc  = {1'b0, r_note_idx} + 6'd1;

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_note_idx;
        w_len_nxt   = r_song_len;
        w_en_nxt    = r_pwm_en;
        w_arr_nxt   = r_pwm_arr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_song_end  = 1'b0;
        if (bus.stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 5'd0;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && (bus.song_len == 6'd0)) begin
                        w_done_nxt = 1'b1;
                    end else if (bus.start) begin
                        w_state_nxt = LOAD;
                        w_idx_nxt   = 5'd0;
                        w_len_nxt   = bus.song_len;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                LOAD: begin
                    w_en_nxt = 1'b0;
                    if (w_code == 4'hF) begin
                        w_song_end = 1'b1;
                    end else begin
                        w_state_nxt = TONE;
                        w_cnt_nxt   = w_tone_cnt;
                        w_en_nxt    = (w_code != 4'h0);
                        if (w_code != 4'h0) begin
                            w_arr_nxt = f_tone_arr(w_code);
                        end else begin
                            w_arr_nxt = r_pwm_arr;
                        end
                    end
                end
                TONE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = CW'(GAP_CYCLES - 1);
                        w_en_nxt    = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                GAP: begin
                    if ((r_cnt == '0) && (w_idx_inc == r_song_len)) begin
                        w_song_end = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_idx_nxt   = w_idx_inc[4:0];
                        w_state_nxt = LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
            case ({w_song_end, bus.loop})
                2'b11: begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = 5'd0;
                    w_en_nxt    = 1'b0;
                end
                2'b10: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_en_nxt    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_note_idx <= 5'd0;
            r_song_len <= 6'd0;
            r_pwm_en   <= 1'b0;
            r_pwm_arr  <= 32'd0;
            r_pwm_ccr  <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_note_idx <= w_idx_nxt;
            r_song_len <= w_len_nxt;
            r_pwm_en   <= w_en_nxt;
            r_pwm_arr  <= w_arr_nxt;
            r_pwm_ccr  <= w_arr_nxt >> DUTY_SHIFT;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Note RAM has no reset; writes during playback are dropped so the song stays stable.
    always_ff @(posedge clk_50mhz) begin
        if (bus.wr_en && !r_busy) begin
            r_ram[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.pwm_en   = r_pwm_en;
    assign bus.pwm_arr  = r_pwm_arr;
    assign bus.pwm_ccr  = r_pwm_ccr;
    assign bus.busy     = r_busy;
    assign bus.note_idx = r_note_idx;
    assign bus.done     = r_done;
endmodule
